// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU in the EX stage.
// It produces {remainder, quotient} for HI/LO, stalls the pipeline while busy,
// pulses ready_o for one cycle with the result, and is cancelled by annul_i.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [5:0]  cnt;
  logic [32:0] rem_q;          // partial remainder, one guard bit
  logic [31:0] quo_q;          // dividend shifting out, quotient shifting in
  logic [31:0] divisor_q;      // |divisor| (or raw for DIVU)
  logic [31:0] dividend_raw_q; // unmodified dividend, returned on divide-by-zero
  logic        signed_q;
  logic        dvd_neg_q;
  logic        dvs_neg_q;

  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        start_ok;

  assign start_ok = start_i & ~annul_i;

  // One restoring step: shift, trial-subtract, keep or restore, then sign fix-up.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_sh  = {rem_q[31:0], quo_q[31]};
    trial   = {1'b0, rem_sh} - {2'b00, divisor_q};
    rem_nxt = trial[33] ? rem_sh : trial[32:0];
    quo_nxt = {quo_q[30:0], ~trial[33]};
    q_fix   = quo_nxt;
    r_fix   = rem_nxt[31:0];
    if (signed_q && (dvd_neg_q ^ dvs_neg_q)) q_fix = -quo_nxt;
    if (signed_q && dvd_neg_q)               r_fix = -rem_nxt[31:0];
  end

  // Next-state logic; a flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (divisor_i == 32'd0) ? DIVZERO : ON;
      DIVZERO: state_nxt = END;
      ON:      if (cnt == 6'd31) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul_i) state_nxt = IDLE;
  end

  // Stall while a division is being accepted or computed, never during a flush.
  always_comb begin
    stall_o = 1'b0;
    if (!annul_i) stall_o = (state == IDLE && start_i) || state == ON || state == DIVZERO;
  end

  assign ready_o = (state == END);

  // State, counter and result registers; these are the only ones reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      result_o <= 64'd0;
    end else begin
      state <= state_nxt;
      if (!annul_i) begin
        case (state)
          IDLE:    if (start_ok) cnt <= 6'd0;
          ON: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) result_o <= {r_fix, q_fix};
          end
          DIVZERO: result_o <= {dividend_raw_q, 32'hFFFF_FFFF};
          default: ;
        endcase
      end
    end
  end

  // Working datapath: loaded on start and shifted each ON cycle.
  // NOTE: these registers carry no reset; they are always loaded on start
  // before being read, so a reset term would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && !annul_i) begin
      if (state == IDLE && start_ok) begin
        signed_q       <= signed_i;
        dvd_neg_q      <= dividend_i[31];
        dvs_neg_q      <= divisor_i[31];
        dividend_raw_q <= dividend_i;
        rem_q          <= 33'd0;
        quo_q          <= (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
        divisor_q      <= (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
      end else if (state == ON) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, flush, back-to-back operation and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cycle   = 0;
  int last_ready = 0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one division in the next cycle, hold start until ready, scramble the
  // operands after cycle 0, and check latency, stall profile and result.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    bit got = 0;
    bit stall_ok = 1;
    step();
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b; annul_i = 1'b0;
    #1;
    check({tag, " stall c0"}, 64'(stall_o), 64'd1);
    for (int c = 1; c <= 40 && !got; c++) begin
      step();
      if (c == 1) begin
        dividend_i = 32'hDEAD_BEEF; divisor_i = 32'h0000_0000; signed_i = ~sgn;
        #1;
      end
      if (ready_o) begin
        got = 1;
        last_ready = cycle;
        check({tag, " latency"}, 64'(c), 64'(lat));
        check({tag, " result"}, result_o, exp);
        check({tag, " stall end"}, 64'(stall_o), 64'd0);
      end else if (!stall_o) begin
        stall_ok = 0;
      end
    end
    check({tag, " ready seen"}, 64'(got), 64'd1);
    check({tag, " stall busy"}, 64'(stall_ok), 64'd1);
    start_i = 1'b0;
  endtask

  initial begin
    int r1;
    bit ready_seen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0;
    step();
    step();
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    rst = 1'b0;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
    do_div("divu 1234/0", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2);
    do_div("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 2);

    // Flush at cycle 10 of a 100/7: back to IDLE, no ready, result retained.
    step();
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    for (int k = 1; k <= 10; k++) step();
    annul_i = 1'b1;
    #1;
    check("annul stall", 64'(stall_o), 64'd0);
    step();
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    check("annul idle stall", 64'(stall_o), 64'd0);
    ready_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) ready_seen = 1;
      step();
    end
    check("annul no ready", 64'(ready_seen), 64'd0);
    check("annul result kept", result_o, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    do_div("divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Back-to-back: second start in the cycle right after the first ready.
    do_div("b2b 50/5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
    r1 = last_ready;
    do_div("b2b 51/5", 1'b0, 32'd51, 32'd5, {32'd1, 32'd10}, 33);
    check("b2b spacing", 64'(last_ready - r1), 64'd34);

    // Synchronous reset in the middle of ON clears all outputs.
    step();
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
    for (int k = 1; k <= 5; k++) step();
    check("pre-rst stall", 64'(stall_o), 64'd1);
    rst = 1'b1; start_i = 1'b0;
    step();
    check("mid rst result", result_o, 64'd0);
    check("mid rst ready", 64'(ready_o), 64'd0);
    check("mid rst stall", 64'(stall_o), 64'd0);
    rst = 1'b0;
    do_div("post rst 51/5", 1'b0, 32'd51, 32'd5, {32'd1, 32'd10}, 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
